drive_sequencer: RTL and testbench

Sequences and arbitrates the direction/torque command pair feeding the motor_control datapath. Two requesters compete for the drive: autonomous, with priority, and manual. The block applies soft torque ramping, enforces ramp-to-zero plus a dead time before any direction change, and handles an emergency stop. It sits between the command sources and motor_control, and its outputs connect directly to motor_control's direction/torque inputs.

---
 rtl/drive_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_drive_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// drive_sequencer
//   Arbitrates between an autonomous requester (priority) and a manual
//   requester, and sequences the direction/torque pair fed to motor_control.
//   Torque moves one level per RAMP_TICKS clocks; any direction change first
//   ramps to zero and holds DEAD_TICKS clocks of dead time. An emergency stop
//   drops torque to zero at once and latches a fault. The fault clears only
//   once estop and both requesters are released, and clearing it passes
//   through dead time.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   auto_valid/dir/torque autonomous command (level-held)
//   man_valid/dir/torque  manual command (level-held)
//   estop                 emergency stop, highest priority
//   direction, torque     registered command pair to motor_control
//   grant_auto            registered: autonomous source owns the drive
//   busy                  state is RAMP or DEAD
//   fault                 emergency stop latched
module drive_sequencer #(
    parameter int RAMP_TICKS = 50000,
    parameter int DEAD_TICKS = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto_valid,
    input  logic [1:0] auto_dir,
    input  logic [1:0] auto_torque,
    input  logic       man_valid,
    input  logic [1:0] man_dir,
    input  logic [1:0] man_torque,
    input  logic       estop,
    output logic [1:0] direction,
    output logic [1:0] torque,
    output logic       grant_auto,
    output logic       busy,
    output logic       fault
);

    localparam int MAX_TICKS = (RAMP_TICKS > DEAD_TICKS) ? RAMP_TICKS : DEAD_TICKS;
    localparam int CW        = $clog2(MAX_TICKS);
    localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_TICKS - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_RUN,
        S_DEAD,
        S_FAULT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [1:0]    direction_nx, torque_nx;
    logic [1:0]    target_dir, target_torque, goal;

    // Source selection. With no requester the target is "stay put at zero
    // torque", so an idle drive never changes direction on its own.
    always_comb begin
        target_dir    = direction;
        target_torque = '0;
        if (auto_valid) begin
            target_dir    = auto_dir;
            target_torque = auto_torque;
        end else if (man_valid) begin
            target_dir    = man_dir;
            target_torque = man_torque;
        end
    end

    // A target in the other direction means "ramp to zero first".
    assign goal = (target_dir == direction) ? target_torque : '0;

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        direction_nx = direction;
        torque_nx    = torque;

        if (estop && state != S_FAULT) begin
            state_nx  = S_FAULT;
            torque_nx = '0;
            count_nx  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    torque_nx    = '0;
                    direction_nx = target_dir;
                    if (target_torque != '0) begin
                        state_nx = S_RAMP;
                        count_nx = '0;
                    end
                end

                // goal is live, so a target change mid-ramp just redirects
                // the next step; the tick counter is not restarted.
                S_RAMP: begin
                    if (torque == goal) begin
                        count_nx = '0;
                        if (torque != '0) begin
                            state_nx = S_RUN;
                        end else if (target_dir != direction) begin
                            state_nx = S_DEAD;
                        end else begin
                            state_nx = S_IDLE;
                        end
                    end else if (count == RAMP_LAST) begin
                        torque_nx = (goal > torque) ? torque + 2'd1 : torque - 2'd1;
                        count_nx  = '0;
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end

                S_RUN: begin
                    if (goal != torque) begin
                        state_nx = S_RAMP;
                        count_nx = '0;
                    end
                end

                S_DEAD: begin
                    torque_nx = '0;
                    if (count == DEAD_LAST) begin
                        state_nx = S_IDLE;
                        count_nx = '0;
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end

                S_FAULT: begin
                    torque_nx = '0;
                    if (!estop && !auto_valid && !man_valid) begin
                        state_nx = S_DEAD;
                        count_nx = '0;
                    end
                end

                default: begin
                    state_nx  = S_IDLE;
                    torque_nx = '0;
                    count_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            direction  <= '0;
            torque     <= '0;
            grant_auto <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            direction  <= direction_nx;
            torque     <= torque_nx;
            grant_auto <= auto_valid;
        end
    end

    assign busy  = (state == S_RAMP) || (state == S_DEAD);
    assign fault = (state == S_FAULT);

    // Safety invariants on every non-reset edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (direction_nx == direction || (state == S_IDLE && torque == '0));
            assert (state_nx == S_FAULT
                    || {1'b0, torque_nx} == {1'b0, torque}
                    || {1'b0, torque_nx} == {1'b0, torque} + 3'd1
                    || {1'b0, torque_nx} + 3'd1 == {1'b0, torque});
            assert (torque == '0 || state == S_RAMP || state == S_RUN);
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer
//   Directed bench for drive_sequencer with RAMP_TICKS=4, DEAD_TICKS=8.
//   A phase/countdown model of the drive runs alongside the DUT and every
//   output is compared against it each cycle; hand-computed latencies and
//   levels pin the model at the interesting points.
module tb_drive_sequencer;

    localparam int RT = 4;
    localparam int DT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       auto_valid = 1'b0;
    logic [1:0] auto_dir = '0;
    logic [1:0] auto_torque = '0;
    logic       man_valid = 1'b0;
    logic [1:0] man_dir = '0;
    logic [1:0] man_torque = '0;
    logic       estop = 1'b0;
    logic [1:0] direction;
    logic [1:0] torque;
    logic       grant_auto;
    logic       busy;
    logic       fault;

    always #5 clk = ~clk;

    drive_sequencer #(
        .RAMP_TICKS(RT),
        .DEAD_TICKS(DT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .auto_valid (auto_valid),
        .auto_dir   (auto_dir),
        .auto_torque(auto_torque),
        .man_valid  (man_valid),
        .man_dir    (man_dir),
        .man_torque (man_torque),
        .estop      (estop),
        .direction  (direction),
        .torque     (torque),
        .grant_auto (grant_auto),
        .busy       (busy),
        .fault      (fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus a countdown of clocks left until the next torque
    // step (ramping) or until dead time ends.
    localparam int P_IDLE  = 0;
    localparam int P_RAMP  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DEAD  = 3;
    localparam int P_FAULT = 4;

    int m_phase = P_IDLE;
    int m_dir = 0;
    int m_tq = 0;
    int m_ga = 0;
    int m_left = 0;
    bit m_live = 1'b0;

    always @(posedge clk) begin
        int tdir;
        int ttq;
        int want;
        if (auto_valid) begin
            tdir = int'(auto_dir);
            ttq  = int'(auto_torque);
        end else if (man_valid) begin
            tdir = int'(man_dir);
            ttq  = int'(man_torque);
        end else begin
            tdir = m_dir;
            ttq  = 0;
        end
        want = (tdir == m_dir) ? ttq : 0;

        if (!rst_n) begin
            m_phase = P_IDLE;
            m_dir   = 0;
            m_tq    = 0;
            m_ga    = 0;
            m_live  = 1'b1;
        end else begin
            m_ga = auto_valid ? 1 : 0;
            if (estop && m_phase != P_FAULT) begin
                m_phase = P_FAULT;
                m_tq    = 0;
            end else begin
                case (m_phase)
                    P_IDLE: begin
                        m_dir = tdir;
                        if (ttq != 0) begin
                            m_phase = P_RAMP;
                            m_left  = RT;
                        end
                    end
                    P_RAMP: begin
                        if (m_tq == want) begin
                            if (m_tq != 0) m_phase = P_RUN;
                            else if (tdir != m_dir) begin
                                m_phase = P_DEAD;
                                m_left  = DT;
                            end else m_phase = P_IDLE;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                m_tq   = (want > m_tq) ? m_tq + 1 : m_tq - 1;
                                m_left = RT;
                            end
                        end
                    end
                    P_RUN: begin
                        if (want != m_tq) begin
                            m_phase = P_RAMP;
                            m_left  = RT;
                        end
                    end
                    P_DEAD: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_IDLE;
                    end
                    default: begin
                        if (!estop && !auto_valid && !man_valid) begin
                            m_phase = P_DEAD;
                            m_left  = DT;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("direction", int'(direction), m_dir);
            check("torque", int'(torque), m_tq);
            check("grant_auto", int'(grant_auto), m_ga);
            check("busy", int'(busy), (m_phase == P_RAMP || m_phase == P_DEAD) ? 1 : 0);
            check("fault", int'(fault), (m_phase == P_FAULT) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_man(input logic v, input logic [1:0] d, input logic [1:0] t);
        man_valid  = v;
        man_dir    = d;
        man_torque = t;
    endtask

    task automatic set_auto(input logic v, input logic [1:0] d, input logic [1:0] t);
        auto_valid  = v;
        auto_dir    = d;
        auto_torque = t;
    endtask

    // Wait (bounded) for a settled RUN/IDLE at the given pair.
    task automatic settle(input int d, input int t, input int limit, input string name);
        int c = 0;
        while (!(int'(direction) == d && int'(torque) == t && !busy && !fault) && c < limit) begin
            tick(1);
            c++;
        end
        check(name, (int'(direction) == d && int'(torque) == t && !busy) ? 1 : 0, 1);
    endtask

    // Clocks until direction equals d, bounded.
    task automatic dir_latency(input int d, input int limit, output int c);
        c = 0;
        do begin
            tick(1);
            c++;
        end while (int'(direction) != d && c < limit);
    endtask

    // Clocks until torque equals t, bounded.
    task automatic tq_latency(input int t, input int limit, output int c);
        c = 0;
        do begin
            tick(1);
            c++;
        end while (int'(torque) != t && c < limit);
    endtask

    initial begin
        int c;
        tick(2);
        check("rst_direction", int'(direction), 0);
        check("rst_torque", int'(torque), 0);
        check("rst_grant", int'(grant_auto), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);

        // 1: ramp 0 -> 3 from IDLE
        rst_n = 1'b1;
        set_man(1'b1, 2'd0, 2'd3);
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            check("t1_torque", int'(torque), (k >= 13) ? 3 : (k >= 9) ? 2 : (k >= 5) ? 1 : 0);
            check("t1_busy", int'(busy), (k <= 13) ? 1 : 0);
            check("t1_grant", int'(grant_auto), 0);
        end

        // 2: reversal 00/3 -> 01/2
        set_man(1'b1, 2'd1, 2'd2);
        dir_latency(1, 60, c);
        check("t2_dir_latency", c, 23);
        check("t2_torque_at_load", int'(torque), 0);
        tick(4);
        check("t2_torque1", int'(torque), 1);
        tick(4);
        check("t2_torque2", int'(torque), 2);
        check("t2_busy_last_step", int'(busy), 1);
        tick(1);
        check("t2_run", int'(busy), 0);

        // 3: autonomous preempts manual, then hands back
        set_man(1'b1, 2'd0, 2'd1);
        settle(0, 1, 80, "t3_man_run");
        set_auto(1'b1, 2'd2, 2'd3);
        tick(1);
        check("t3_grant_on", int'(grant_auto), 1);
        dir_latency(2, 60, c);
        check("t3_dir_latency", c + 1, 15);
        settle(2, 3, 60, "t3_auto_run");
        set_auto(1'b0, 2'd2, 2'd3);
        tick(1);
        check("t3_grant_off", int'(grant_auto), 0);
        settle(0, 1, 80, "t3_back_to_man");

        // 4: estop mid-ramp
        set_man(1'b1, 2'd0, 2'd3);
        tq_latency(2, 20, c);
        check("t4_reach2", c, 5);
        estop = 1'b1;
        tick(1);
        check("t4_torque0", int'(torque), 0);
        check("t4_fault", int'(fault), 1);
        tick(3);
        estop = 1'b0;
        set_auto(1'b1, 2'd1, 2'd1);
        tick(5);
        check("t4_held_fault", int'(fault), 1);
        set_auto(1'b0, 2'd0, 2'd0);
        set_man(1'b0, 2'd0, 2'd0);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check("t4_fault_clear", int'(fault), 0);
            check("t4_dead_busy", int'(busy), (k <= 8) ? 1 : 0);
        end

        // 5: target lowered mid-ramp
        set_man(1'b1, 2'd0, 2'd3);
        tq_latency(2, 20, c);
        check("t5_reach2", c, 9);
        set_man(1'b1, 2'd0, 2'd1);
        tick(3);
        check("t5_hold2", int'(torque), 2);
        tick(1);
        check("t5_step1", int'(torque), 1);
        check("t5_busy", int'(busy), 1);
        tick(1);
        check("t5_run", int'(busy), 0);

        // 6: reset mid-DEAD, then mid-RAMP
        set_man(1'b1, 2'd1, 2'd1);
        tick(8);
        check("t6_in_dead", int'(busy), 1);
        rst_n = 1'b0;
        estop = 1'b1;
        set_auto(1'b1, 2'd3, 2'd3);
        tick(1);
        check("t6a_busy", int'(busy), 0);
        check("t6a_fault", int'(fault), 0);
        check("t6a_grant", int'(grant_auto), 0);
        rst_n = 1'b1;
        estop = 1'b0;
        set_auto(1'b0, 2'd0, 2'd0);
        set_man(1'b1, 2'd1, 2'd3);
        tick(6);
        check("t6_pre_dir", int'(direction), 1);
        check("t6_pre_torque", int'(torque), 1);
        rst_n = 1'b0;
        estop = 1'b1;
        set_auto(1'b1, 2'd2, 2'd2);
        tick(1);
        check("t6b_direction", int'(direction), 0);
        check("t6b_torque", int'(torque), 0);
        check("t6b_busy", int'(busy), 0);
        check("t6b_fault", int'(fault), 0);
        check("t6b_grant", int'(grant_auto), 0);
        rst_n = 1'b1;
        estop = 1'b0;
        set_auto(1'b0, 2'd0, 2'd0);
        set_man(1'b0, 2'd0, 2'd0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
